// File: rtl/soc_system_pio_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_pio_read_arbiter_pkg
// Shared definitions for the PIO read arbiter and its round-robin picker:
//   - state_t      : arbiter FSM state encoding
//   - DEF_*        : default widths / requester count
//   - idx_w()      : width of an index that can address n requesters
// -----------------------------------------------------------------------------
package soc_system_pio_read_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_system_rr_pick.sv
// -----------------------------------------------------------------------------
// soc_system_rr_pick
// Purely combinational round-robin picker. Searches i_ptr, i_ptr+1, ...
// (modulo NUM_REQ) and reports the first requesting index.
// Ports:
//   i_req  [NUM_REQ-1:0] request vector
//   i_ptr  [IDX_W-1:0]   highest-priority index for this round
//   o_idx  [IDX_W-1:0]   winning index (0 when nothing requests)
//   o_any               at least one request is pending
// -----------------------------------------------------------------------------
module soc_system_rr_pick
    import soc_system_pio_read_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the lowest priority offset to the highest so the closest
    // requester to i_ptr overwrites the others and ends up as the winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_system_pio_read_arbiter.sv
// -----------------------------------------------------------------------------
// soc_system_pio_read_arbiter
// Shares one read-only Avalon-MM PIO slave (no read strobe, one-cycle
// registered readdata) among NUM_REQ Avalon-MM read requesters, one
// transaction at a time, in round-robin order.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_read        [N]    per-requester read request
//   req_address     [N*A]  requester i address at [i*ADDR_W +: ADDR_W]
//   req_waitrequest [N]    per-requester waitrequest (low for one cycle = done)
//   req_readdata    [D]    shared return data, valid for the acked requester
//   pio_address     [A]    address presented to the PIO slave
//   pio_readdata    [D]    registered data from the PIO slave
//   busy                   high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module soc_system_pio_read_arbiter
    import soc_system_pio_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [ADDR_W-1:0]         pio_address,
    input  logic [DATA_W-1:0]         pio_readdata,
    output logic                      busy
);

    localparam int               IDX_W    = idx_w(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_win_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_ack;
    logic [ADDR_W-1:0]  r_pio_address;
    logic [DATA_W-1:0]  r_readdata;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any_req;

    soc_system_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req (req_read),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_any_req)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state is updated with <= so every register samples
        // pre-edge values regardless of statement or block ordering.
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. SETTLE covers the slave's registered latency: it
    // samples the new address on that edge, so data is ready in CAPTURE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy            = (r_state != IDLE);
        req_waitrequest = ~r_ack;
        pio_address     = r_pio_address;
        req_readdata    = r_readdata;
    end

    // Transaction datapath. The address is latched at grant so later
    // changes on req_address cannot disturb an in-flight read. A requester
    // that drops req_read mid-transaction still gets its ack pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_idx     <= '0;
            r_rr_ptr      <= '0;
            r_ack         <= '0;
            r_pio_address <= '0;
            r_readdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_win_idx     <= w_pick_idx;
                        r_pio_address <= req_address[int'(w_pick_idx) * ADDR_W +: ADDR_W];
                    end
                end
                CAPTURE: begin
                    r_readdata       <= pio_readdata;
                    r_ack[r_win_idx] <= 1'b1;
                end
                RESP: begin
                    r_ack    <= '0;
                    r_rr_ptr <= (r_win_idx == LAST_IDX) ? '0 : r_win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_pio_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_soc_system_pio_read_arbiter
// Directed bench with a scoreboard. Each issued read pushes its expected
// (requester, data, ack cycle); a monitor pops and compares every time a
// waitrequest goes low. A registered PIO slave model returns in_port for
// address 0 and zero for any other address.
// -----------------------------------------------------------------------------
module tb_soc_system_pio_read_arbiter;
    import soc_system_pio_read_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 32;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [ADDR_W-1:0]         pio_address;
    logic [DATA_W-1:0]         pio_readdata;
    logic                      busy;

    logic [1:0]         in_port;
    logic [NUM_REQ-1:0] hold;
    exp_t               sb[$];
    int                 cyc   = 0;
    int                 n_cmp = 0;
    int                 n_err = 0;

    soc_system_pio_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_read        (req_read),
        .req_address     (req_address),
        .req_waitrequest (req_waitrequest),
        .req_readdata    (req_readdata),
        .pio_address     (pio_address),
        .pio_readdata    (pio_readdata),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: readdata registered every clock from the current address.
    always @(posedge clk) pio_readdata <= (pio_address == 2'd0) ? DATA_W'(in_port) : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; a requester whose waitrequest was low at the edge drops
    // req_read afterwards unless it is in the hold mask.
    task automatic step();
        logic [NUM_REQ-1:0] acked;
        @(negedge clk);
        acked = ~req_waitrequest;
        @(posedge clk);
        #1;
        req_read = req_read & ~(acked & ~hold);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic expect_ack(input int idx, input logic [31:0] data, input int c);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_address[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int                 c;
        int                 mon_idx;
        logic [NUM_REQ-1:0] mon_ack;
        exp_t               mon_e;

        reset_n     = 1'b0;
        req_read    = '0;
        req_address = '0;
        in_port     = 2'b00;
        hold        = '0;

        // Monitor: every cycle with a waitrequest low must match the
        // oldest scoreboard entry in requester, data and cycle.
        fork
            forever begin
                @(negedge clk);
                if (reset_n && req_waitrequest != '1) begin
                    mon_ack = ~req_waitrequest;
                    check("ack_onehot", $countones(mon_ack), 1);
                    mon_idx = 0;
                    for (int i = 0; i < NUM_REQ; i++) if (mon_ack[i]) mon_idx = i;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL stray_ack: got waitrequest %b expected none low (cycle %0d)",
                                 req_waitrequest, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("grant_idx", mon_idx, mon_e.idx);
                        check("readdata", req_readdata, mon_e.data);
                        check("ack_cycle", mon_ack == 0 ? 0 : cyc, mon_e.cyc);
                    end
                end
            end
        join_none

        // Reset state.
        @(posedge clk);
        #1;
        check("rst_waitrequest", req_waitrequest, 4'b1111);
        check("rst_busy", busy, 0);
        check("rst_pio_address", pio_address, 0);
        check("rst_readdata", req_readdata, 0);
        reset_n = 1'b1;

        // Single read: requester 1, address 0, in_port = 2'b10.
        in_port  = 2'b10;
        set_addr(1, 2'd0);
        req_read = 4'b0010;
        c        = cyc;
        expect_ack(1, 32'h2, c + 3);
        step();
        check("t1_busy_settle", busy, 1);
        steps(7);
        check("t1_idle", busy, 0);

        // All four at once from reset: order 0,1,2,3, four cycles apart.
        do_reset();
        in_port  = 2'b01;
        req_read = 4'b1111;
        c        = cyc;
        expect_ack(0, 32'h1, c + 3);
        expect_ack(1, 32'h1, c + 7);
        expect_ack(2, 32'h1, c + 11);
        expect_ack(3, 32'h1, c + 15);
        steps(18);
        check("t2_idle", busy, 0);

        // Fairness: 0 and 2 hold req_read; grants alternate 0,2,0,2.
        in_port  = 2'b11;
        hold     = 4'b0101;
        req_read = 4'b0101;
        c        = cyc;
        expect_ack(0, 32'h3, c + 3);
        expect_ack(2, 32'h3, c + 7);
        expect_ack(0, 32'h3, c + 11);
        expect_ack(2, 32'h3, c + 15);
        steps(16);
        req_read = '0;
        hold     = '0;
        steps(2);

        // Nonzero address 2 reads 0; address change after grant is ignored.
        in_port = 2'b11;
        set_addr(3, 2'd2);
        req_read = 4'b1000;
        c        = cyc;
        expect_ack(3, 32'h0, c + 3);
        step();
        check("t4_pio_addr_settle", pio_address, 2);
        set_addr(3, 2'd0);
        step();
        check("t4_pio_addr_capture", pio_address, 2);
        steps(4);
        check("t4_pio_addr_hold", pio_address, 2);

        // Reset during CAPTURE, with rr_ptr moved to 2 beforehand.
        in_port = 2'b10;
        set_addr(1, 2'd0);
        req_read = 4'b0010;
        c        = cyc;
        expect_ack(1, 32'h2, c + 3);
        steps(6);
        set_addr(1, 2'd1);
        req_read = 4'b0010;
        steps(2);
        check("t5_busy_capture", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_waitrequest", req_waitrequest, 4'b1111);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_pio_address", pio_address, 0);
        check("t5_rst_readdata", req_readdata, 0);
        req_read = '0;
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        in_port     = 2'b01;
        req_address = '0;
        req_read    = 4'b1101;
        c           = cyc;
        expect_ack(0, 32'h1, c + 3);
        expect_ack(2, 32'h1, c + 7);
        expect_ack(3, 32'h1, c + 11);
        steps(14);

        // Requester 2 drops req_read in SETTLE; its ack still pulses and
        // the pointer moves on, so 3 beats 1 in the next round.
        in_port  = 2'b10;
        req_read = 4'b0100;
        c        = cyc;
        expect_ack(2, 32'h2, c + 3);
        expect_ack(3, 32'h2, c + 7);
        expect_ack(1, 32'h2, c + 11);
        step();
        req_read = 4'b1010;
        steps(14);
        check("t6_idle", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
